// File: rtl/fp_mult_round_norm_if.sv
// Beat/result bus for the binary32 multiplier round/normalize stage.
// The master side drives the product beat and out_ready; the slave side is the stage itself.
interface fp_mult_round_norm_if #(
  parameter int EXP_W = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic signed [EXP_W-1:0] in_exp;
  logic [47:0]             in_mant;
  logic [1:0]              in_cls;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_result;
  logic [3:0]              out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_cls, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_cls, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_mult_round_norm.sv
// Normalize, round (nearest-even or truncate) and encode a raw 48-bit significand product to binary32.
// Two registered stages, 2-cycle latency; a full pipe with out_ready low drops in_ready the same cycle.
module fp_mult_round_norm #(
  parameter int EXP_W    = 10,
  parameter bit ROUND_EN = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  fp_mult_round_norm_if.slave bus
);
  localparam logic [1:0] CLS_NORM = 2'b00;
  localparam logic [1:0] CLS_ZERO = 2'b01;
  localparam logic [1:0] CLS_INF  = 2'b10;
  localparam logic signed [EXP_W:0] EXP_TOP  = 255;
  localparam logic signed [EXP_W:0] EXP_ZERO = 0;

  logic                    s1_valid_q;
  logic                    s1_sign_q;
  logic [1:0]              s1_cls_q;
  logic signed [EXP_W-1:0] s1_exp_q;
  logic [22:0]             s1_frac_q;
  logic                    s1_g_q;
  logic                    s1_s_q;

  logic                    s2_valid_q;
  logic [31:0]             out_result_q;
  logic [3:0]              out_flags_q;

  logic                    s2_adv;
  logic                    in_fire;

  logic signed [EXP_W-1:0] s1_exp_d;
  logic [22:0]             s1_frac_d;
  logic                    s1_g_d;
  logic                    s1_s_d;

  logic                    round_up;
  logic [23:0]             frac_rnd;
  logic signed [EXP_W:0]   exp_rnd;
  logic [31:0]             out_result_d;
  logic [3:0]              out_flags_d;

  assign s2_adv       = ~s2_valid_q | bus.out_ready;
  assign bus.in_ready = ~s1_valid_q | s2_adv;
  assign in_fire      = bus.in_valid & bus.in_ready;

  assign bus.out_valid  = s2_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_flags  = out_flags_q;

  // A leading one at bit 47 means the product is in [2,4): shift right one and bump the exponent.
  always_comb begin
    s1_exp_d  = bus.in_exp;
    s1_frac_d = bus.in_mant[45:23];
    s1_g_d    = bus.in_mant[22];
    s1_s_d    = |bus.in_mant[21:0];
    if (bus.in_mant[47]) begin
      s1_exp_d  = bus.in_exp + $signed({{(EXP_W-1){1'b0}}, 1'b1});
      s1_frac_d = bus.in_mant[46:24];
      s1_g_d    = bus.in_mant[23];
      s1_s_d    = |bus.in_mant[22:0];
    end
  end

  // Carry out of the rounded fraction lands in bit 23 and is folded into the exponent.
  assign round_up = ROUND_EN & s1_g_q & (s1_s_q | s1_frac_q[0]);
  assign frac_rnd = {1'b0, s1_frac_q} + {23'd0, round_up};
  assign exp_rnd  = {s1_exp_q[EXP_W-1], s1_exp_q} + $signed({{EXP_W{1'b0}}, frac_rnd[23]});

  always_comb begin
    out_result_d = {s1_sign_q, 31'h0};
    out_flags_d  = 4'b0000;
    case (s1_cls_q)
      CLS_NORM: begin
        if (exp_rnd >= EXP_TOP) begin
          out_result_d = {s1_sign_q, 8'hFF, 23'h0};
          out_flags_d  = 4'b0101;
        end else if (exp_rnd <= EXP_ZERO) begin
          out_result_d = {s1_sign_q, 31'h0};
          out_flags_d  = 4'b0011;
        end else begin
          out_result_d = {s1_sign_q, exp_rnd[7:0], frac_rnd[22:0]};
          out_flags_d  = {3'b000, s1_g_q | s1_s_q};
        end
      end
      CLS_ZERO: out_result_d = {s1_sign_q, 31'h0};
      CLS_INF:  out_result_d = {s1_sign_q, 8'hFF, 23'h0};
      default: begin
        out_result_d = 32'h7FC00000;
        out_flags_d  = 4'b1000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_cls_q     <= 2'b00;
      s1_exp_q     <= '0;
      s1_frac_q    <= '0;
      s1_g_q       <= 1'b0;
      s1_s_q       <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      if (bus.in_ready) s1_valid_q <= bus.in_valid;
      if (in_fire) begin
        s1_sign_q <= bus.in_sign;
        s1_cls_q  <= bus.in_cls;
        s1_exp_q  <= s1_exp_d;
        s1_frac_q <= s1_frac_d;
        s1_g_q    <= s1_g_d;
        s1_s_q    <= s1_s_d;
      end
      if (s2_adv) s2_valid_q <= s1_valid_q;
      // Output registers only change on a real hand-off so they hold while stalled.
      if (s2_adv && s1_valid_q) begin
        out_result_q <= out_result_d;
        out_flags_q  <= out_flags_d;
      end
    end
  end
endmodule
